seg_decoder: RTL and testbench
==============================

SEG_DECODER -- requirements
Module: seg_decoder

Interface
REQ-001 Parameter STABLE_CYCLES, default 4, legal range 2..15: consecutive cycles a segment pattern must hold before it is accepted.
REQ-002 sys_clk  input  1  single clock; all logic on the rising edge.
REQ-003 reset_n  input  1  asynchronous, active-low reset.
REQ-004 cfg_cathode_mode  input  1  1 = segments active-high (common cathode); 0 = segments active-low (common anode).
REQ-005 seg_in  input  7  segment lines, bit0 = a through bit6 = g.
REQ-006 hex_out  output  4  last accepted decoded hex digit.
REQ-007 hex_valid  output  1  high while the last accepted pattern was a legal digit.
REQ-008 hex_strobe  output  1  one-cycle pulse when a new digit is accepted.
REQ-009 seg_err  output  1  one-cycle pulse when an illegal pattern is accepted.
REQ-010 err_count  output  8  saturating count of seg_err pulses.

Function
REQ-011 The block shall register seg_in every cycle and normalise it: invert when cfg_cathode_mode=0, pass unchanged when 1.
REQ-012 Legal normalised patterns (hex) shall be: 0:3F, 1:06, 2:5B, 3:4F, 4:66, 5:6D, 6:7D, 7:07, 8:7F, 9:6F, A:77, b:7C, C:39, d:5E, E:79, F:71.
REQ-013 Normalised 00 shall be BLANK, and every other pattern shall be ILLEGAL.
REQ-014 A 4-bit stability counter shall clear on any edge where the normalised sample differs from the previous one, increment otherwise, and saturate at STABLE_CYCLES.
REQ-015 If a pattern is first captured at edge k and held, acceptance shall occur at edge k+STABLE_CYCLES, with outputs updated at that edge.
REQ-016 Each held pattern shall be accepted exactly once, with no repeat pulses while it remains held.
REQ-017 FSM states shall be IDLE (nothing accepted since reset), SETTLE (counter below STABLE_CYCLES) and LOCKED (pattern accepted).
REQ-018 Any sample change shall move the FSM to SETTLE; acceptance shall move it to LOCKED.
REQ-019 On acceptance of a legal pattern: hex_out <= digit and hex_valid <= 1.
REQ-020 hex_strobe shall pulse on legal acceptance only if hex_valid was 0 or the digit differs from the current hex_out.
REQ-021 On acceptance of BLANK: hex_valid <= 0, hex_out held, and no strobe or error.
REQ-022 On acceptance of ILLEGAL: seg_err pulses, err_count increments (saturating at 255), hex_valid <= 0 and hex_out is held.
REQ-023 During SETTLE, hex_out and hex_valid shall hold their previous values; a glitch shorter than STABLE_CYCLES shall cause no output change.
REQ-024 A cfg_cathode_mode toggle shall be treated as an input change: the normalised sample changes and settling restarts.
REQ-025 hex_strobe and seg_err shall never assert in the same cycle.

Reset
REQ-026 While reset_n=0: hex_out=0, hex_valid=0, hex_strobe=0, seg_err=0, err_count=0, FSM=IDLE, counter=0, and the normalised sample register holds 00 (BLANK).
REQ-027 Reset assertion mid-SETTLE or mid-LOCKED shall take effect immediately and discard the pending pattern.
REQ-028 After reset release, normal settling shall apply from the first captured edge.

Structure
REQ-029 The shared package seg_pkg shall hold the 16 segment pattern constants (the same table used by the segment display driver), the BLANK constant, the FSM state encoding and the STABLE_CYCLES default.
REQ-030 One combinational sub-module, seg_lookup, shall map a normalised 7-bit pattern to {legal, blank, digit[3:0]}.
REQ-031 All other logic (sampling, counter, FSM, error counter) shall reside in seg_decoder.

Verification
REQ-032 cathode_mode=1, seg_in=5B held from edge 10 with STABLE_CYCLES=4 -> hex_out=2, hex_valid=1, one-cycle hex_strobe at edge 14, no further strobes.
REQ-033 cathode_mode=0, seg_in=~77 (08) held -> hex_out=A accepted; then a 2-cycle glitch to 08^01 and back -> no output change, no strobe.
REQ-034 seg_in=49 held (illegal) -> single seg_err pulse, err_count=1, hex_valid=0, hex_out unchanged; 300 alternating illegal/blank acceptances -> err_count saturates at 255.
REQ-035 Locked on 7, then seg_in=00 held -> hex_valid=0, hex_out=7, no strobe or error; then 07 again -> strobe, hex_valid=1.
REQ-036 Sweep all 16 digits, each held 6 cycles, with cathode_mode=0 and then 1 -> each digit decoded correctly, exactly one strobe per digit.
REQ-037 reset_n pulsed low while SETTLE is at count 3 -> all outputs 0 asynchronously, and the pattern is re-accepted STABLE_CYCLES edges after release.

Source files
------------

// File: rtl/seg_pkg.sv
// Shared definitions for seven-segment decode: pattern table, FSM encoding, widths.
`timescale 1ns/1ps
package seg_pkg;

  localparam int unsigned SEG_W     = 7;
  localparam int unsigned DIGIT_W   = 4;
  localparam int unsigned CNT_W     = 4;
  localparam int unsigned ERR_W     = 8;
  localparam int unsigned NUM_DIGIT = 16;

  localparam int unsigned STABLE_CYCLES_DEF = 4;

  // Active-high segment patterns, bit0 = a .. bit6 = g
  localparam logic [SEG_W-1:0] SEG_0 = 7'h3F;
  localparam logic [SEG_W-1:0] SEG_1 = 7'h06;
  localparam logic [SEG_W-1:0] SEG_2 = 7'h5B;
  localparam logic [SEG_W-1:0] SEG_3 = 7'h4F;
  localparam logic [SEG_W-1:0] SEG_4 = 7'h66;
  localparam logic [SEG_W-1:0] SEG_5 = 7'h6D;
  localparam logic [SEG_W-1:0] SEG_6 = 7'h7D;
  localparam logic [SEG_W-1:0] SEG_7 = 7'h07;
  localparam logic [SEG_W-1:0] SEG_8 = 7'h7F;
  localparam logic [SEG_W-1:0] SEG_9 = 7'h6F;
  localparam logic [SEG_W-1:0] SEG_A = 7'h77;
  localparam logic [SEG_W-1:0] SEG_B = 7'h7C;
  localparam logic [SEG_W-1:0] SEG_C = 7'h39;
  localparam logic [SEG_W-1:0] SEG_D = 7'h5E;
  localparam logic [SEG_W-1:0] SEG_E = 7'h79;
  localparam logic [SEG_W-1:0] SEG_F = 7'h71;

  localparam logic [SEG_W-1:0] SEG_BLANK = 7'h00;

  // Entry i holds the pattern for hex digit i
  localparam logic [NUM_DIGIT-1:0][SEG_W-1:0] SEG_TABLE = {
    SEG_F, SEG_E, SEG_D, SEG_C, SEG_B, SEG_A, SEG_9, SEG_8,
    SEG_7, SEG_6, SEG_5, SEG_4, SEG_3, SEG_2, SEG_1, SEG_0
  };

  typedef enum logic [1:0] {
    ST_IDLE   = 2'd0,
    ST_SETTLE = 2'd1,
    ST_LOCKED = 2'd2
  } seg_state_e;

  typedef struct packed {
    logic               legal;
    logic               blank;
    logic [DIGIT_W-1:0] digit;
  } seg_lookup_t;

endpackage

// File: rtl/seg_lookup.sv
// Combinational map from a normalised segment pattern to {legal, blank, digit}.
`timescale 1ns/1ps
module seg_lookup
  import seg_pkg::*;
(
  input  logic [SEG_W-1:0] pattern_i,
  output seg_lookup_t      lookup_o
);

  // Scan the digit table; at most one entry can match since all patterns are distinct
  always_comb begin
    lookup_o       = '0;
    lookup_o.blank = (pattern_i == SEG_BLANK);
    for (int unsigned i = 0; i < NUM_DIGIT; i++) begin
      if (pattern_i == SEG_TABLE[DIGIT_W'(i)]) begin
        lookup_o.legal = 1'b1;
        lookup_o.digit = DIGIT_W'(i);
      end
    end
  end

endmodule

// File: rtl/seg_decoder.sv
// Debounced seven-segment to hex decoder: samples, normalises polarity, waits for a
// stable pattern, then publishes the digit, a change strobe, or an error pulse.
`timescale 1ns/1ps
module seg_decoder
  import seg_pkg::*;
#(
  parameter int unsigned STABLE_CYCLES = STABLE_CYCLES_DEF
) (
  input  logic               sys_clk,
  input  logic               reset_n,
  input  logic               cfg_cathode_mode,
  input  logic [SEG_W-1:0]   seg_in,
  output logic [DIGIT_W-1:0] hex_out,
  output logic               hex_valid,
  output logic               hex_strobe,
  output logic               seg_err,
  output logic [ERR_W-1:0]   err_count
);

  localparam logic [CNT_W-1:0] CNT_SAT    = CNT_W'(STABLE_CYCLES);
  localparam logic [CNT_W-1:0] CNT_ACCEPT = CNT_W'(STABLE_CYCLES - 1);
  localparam logic [ERR_W-1:0] ERR_MAX    = '1;

  seg_state_e         state_q, state_d;
  logic [SEG_W-1:0]   sample_q, sample_d;
  logic [CNT_W-1:0]   cnt_q, cnt_d;
  logic [DIGIT_W-1:0] hex_q, hex_d;
  logic               valid_q, valid_d;
  logic               strobe_q, strobe_d;
  logic               err_q, err_d;
  logic [ERR_W-1:0]   errcnt_q, errcnt_d;

  logic [SEG_W-1:0]   norm_c;
  logic               changed_c;
  logic               accept_c;
  seg_lookup_t        lk_c;

  // Polarity normalisation: common anode drives segments low
  assign norm_c    = cfg_cathode_mode ? seg_in : ~seg_in;
  assign changed_c = (norm_c != sample_q);
  // Acceptance lands on the edge that brings the counter to saturation, once per hold
  assign accept_c  = (state_q != ST_LOCKED) && !changed_c && (cnt_q == CNT_ACCEPT);

  // Decode the held sample; it equals norm_c whenever acceptance fires
  seg_lookup u_lookup (
    .pattern_i (sample_q),
    .lookup_o  (lk_c)
  );

  // Next-state logic: settling counter, FSM, and accepted-pattern outputs
  always_comb begin
    sample_d = norm_c;
    cnt_d    = cnt_q;
    state_d  = state_q;
    hex_d    = hex_q;
    valid_d  = valid_q;
    strobe_d = 1'b0;
    err_d    = 1'b0;
    errcnt_d = errcnt_q;

    if (changed_c) begin
      cnt_d   = '0;
      state_d = ST_SETTLE;
    end else begin
      if (cnt_q != CNT_SAT) begin
        cnt_d = cnt_q + CNT_W'(1);
      end
      if (accept_c) begin
        state_d = ST_LOCKED;
        if (lk_c.legal) begin
          hex_d    = lk_c.digit;
          valid_d  = 1'b1;
          strobe_d = !valid_q || (lk_c.digit != hex_q);
        end else if (lk_c.blank) begin
          valid_d = 1'b0;
        end else begin
          valid_d = 1'b0;
          err_d   = 1'b1;
          if (errcnt_q != ERR_MAX) begin
            errcnt_d = errcnt_q + ERR_W'(1);
          end
        end
      end
    end
  end

  // State and output registers; reset discards any pending pattern
  always_ff @(posedge sys_clk or negedge reset_n) begin
    if (!reset_n) begin
      state_q  <= ST_IDLE;
      sample_q <= SEG_BLANK;
      cnt_q    <= '0;
      hex_q    <= '0;
      valid_q  <= 1'b0;
      strobe_q <= 1'b0;
      err_q    <= 1'b0;
      errcnt_q <= '0;
    end else begin
      state_q  <= state_d;
      sample_q <= sample_d;
      cnt_q    <= cnt_d;
      hex_q    <= hex_d;
      valid_q  <= valid_d;
      strobe_q <= strobe_d;
      err_q    <= err_d;
      errcnt_q <= errcnt_d;
    end
  end

  assign hex_out    = hex_q;
  assign hex_valid  = valid_q;
  assign hex_strobe = strobe_q;
  assign seg_err    = err_q;
  assign err_count  = errcnt_q;

endmodule

// File: tb/tb_seg_decoder.sv
// Scoreboard bench for seg_decoder: directed vectors push expected events, a
// negedge monitor pops and checks them on every strobe or error pulse.
`timescale 1ns/1ps
module tb_seg_decoder;

  localparam int unsigned S = 4;

  localparam int EV_NONE   = 0;
  localparam int EV_STROBE = 1;
  localparam int EV_ERR    = 2;

  logic       clk = 1'b0;
  logic       rst_n = 1'b0;
  logic       mode = 1'b1;
  logic [6:0] seg = 7'h00;
  logic [3:0] hex_out;
  logic       hex_valid;
  logic       hex_strobe;
  logic       seg_err;
  logic [7:0] err_count;

  typedef struct {
    bit          is_err;
    logic [3:0]  digit;
    logic [7:0]  cnt;
    int unsigned cyc;
  } ev_t;

  ev_t         q[$];
  int          checks = 0;
  int          failures = 0;
  int unsigned cyc = 0;
  int          exp_err = 0;

  // Hand-written active-high patterns for digits 0..F
  logic [6:0] pat_tab [16] = '{7'h3F, 7'h06, 7'h5B, 7'h4F, 7'h66, 7'h6D, 7'h7D, 7'h07,
                               7'h7F, 7'h6F, 7'h77, 7'h7C, 7'h39, 7'h5E, 7'h79, 7'h71};

  seg_decoder #(.STABLE_CYCLES(S)) dut (
    .sys_clk          (clk),
    .reset_n          (rst_n),
    .cfg_cathode_mode (mode),
    .seg_in           (seg),
    .hex_out          (hex_out),
    .hex_valid        (hex_valid),
    .hex_strobe       (hex_strobe),
    .seg_err          (seg_err),
    .err_count        (err_count)
  );

  always #5 clk = ~clk;

  always @(posedge clk) cyc <= cyc + 1;

  task automatic chk(input string name, input int got, input int exp);
    checks++;
    if (got != exp) begin
      failures++;
      $display("FAIL %s got=%0d exp=%0d t=%0t", name, got, exp, $time);
    end
  endtask

  // Drive a vector from a negedge, record its expected event, hold for n cycles
  task automatic apply(input logic m, input logic [6:0] raw, input int n,
                       input int kind, input int val);
    ev_t ev;
    mode = m;
    seg  = raw;
    if (kind != EV_NONE) begin
      ev.is_err = (kind == EV_ERR);
      ev.digit  = 4'(val);
      ev.cnt    = 8'(val);
      ev.cyc    = cyc + 1 + S;
      q.push_back(ev);
    end
    repeat (n) @(negedge clk);
  endtask

  // Monitor: every output pulse must match the oldest expected event
  always @(negedge clk) begin
    ev_t ev;
    if (hex_strobe && seg_err) chk("strobe_err_overlap", 1, 0);
    if (hex_strobe || seg_err) begin
      checks++;
      if (q.size() == 0) begin
        failures++;
        $display("FAIL unexpected_event strobe=%0d err=%0d hex=%0d cyc=%0d",
                 hex_strobe, seg_err, hex_out, cyc);
      end else begin
        ev = q.pop_front();
        chk("ev_kind_is_err", int'(seg_err), int'(ev.is_err));
        chk("ev_cycle", int'(cyc), int'(ev.cyc));
        if (ev.is_err) chk("ev_err_count", int'(err_count), int'(ev.cnt));
        else           chk("ev_digit", int'(hex_out), int'(ev.digit));
      end
    end
  end

  initial begin
    #500000;
    $display("FAIL watchdog_timeout checks=%0d", checks);
    $fatal(1, "watchdog");
  end

  initial begin
    // Reset state
    #7;
    chk("rst_hex_out", int'(hex_out), 0);
    chk("rst_hex_valid", int'(hex_valid), 0);
    chk("rst_strobe", int'(hex_strobe), 0);
    chk("rst_seg_err", int'(seg_err), 0);
    chk("rst_err_count", int'(err_count), 0);
    @(negedge clk);
    rst_n = 1'b1;

    // Blank held from reset: accepted silently
    apply(1'b1, 7'h00, 6, EV_NONE, 0);
    chk("blank_valid", int'(hex_valid), 0);

    // Common cathode digit 2
    apply(1'b1, 7'h5B, 8, EV_STROBE, 2);
    chk("d2_hex_out", int'(hex_out), 2);
    chk("d2_valid", int'(hex_valid), 1);

    // Common anode digit A, then a short glitch and return
    apply(1'b0, 7'h08, 8, EV_STROBE, 10);
    chk("dA_hex_out", int'(hex_out), 10);
    apply(1'b0, 7'h09, 2, EV_NONE, 0);
    chk("glitch_hex_out", int'(hex_out), 10);
    chk("glitch_valid", int'(hex_valid), 1);
    apply(1'b0, 7'h08, 8, EV_NONE, 0);
    chk("post_glitch_hex_out", int'(hex_out), 10);
    chk("post_glitch_valid", int'(hex_valid), 1);

    // Illegal pattern
    exp_err = 1;
    apply(1'b1, 7'h49, 8, EV_ERR, exp_err);
    chk("ill_err_count", int'(err_count), 1);
    chk("ill_valid", int'(hex_valid), 0);
    chk("ill_hex_out", int'(hex_out), 10);

    // Alternate blank/illegal until the error counter saturates
    for (int i = 0; i < 300; i++) begin
      apply(1'b1, 7'h00, 5, EV_NONE, 0);
      exp_err = (exp_err < 255) ? exp_err + 1 : 255;
      apply(1'b1, 7'h49, 5, EV_ERR, exp_err);
    end
    chk("err_sat", int'(err_count), 255);

    // Lock on 7, blank it, then 7 again
    apply(1'b1, 7'h07, 6, EV_STROBE, 7);
    apply(1'b1, 7'h00, 6, EV_NONE, 0);
    chk("blank7_valid", int'(hex_valid), 0);
    chk("blank7_hex_out", int'(hex_out), 7);
    apply(1'b1, 7'h07, 6, EV_STROBE, 7);
    chk("relock7_valid", int'(hex_valid), 1);

    // Sweep all digits in both polarities
    for (int m = 0; m < 2; m++) begin
      for (int d = 0; d < 16; d++) begin
        logic [6:0] p;
        p = pat_tab[d];
        apply(m[0], (m == 1) ? p : ~p, 6, EV_STROBE, d);
        chk("sweep_hex_out", int'(hex_out), d);
        chk("sweep_valid", int'(hex_valid), 1);
      end
    end

    // Reset mid-settle (counter at 3), then re-accept after release
    apply(1'b1, 7'h06, 4, EV_NONE, 0);
    #2 rst_n = 1'b0;
    #1;
    chk("arst_hex_out", int'(hex_out), 0);
    chk("arst_valid", int'(hex_valid), 0);
    chk("arst_err_count", int'(err_count), 0);
    chk("arst_strobe", int'(hex_strobe), 0);
    @(negedge clk);
    rst_n = 1'b1;
    apply(1'b1, 7'h06, 8, EV_STROBE, 1);
    chk("post_rst_hex_out", int'(hex_out), 1);
    chk("post_rst_valid", int'(hex_valid), 1);

    repeat (4) @(negedge clk);
    chk("queue_drained", q.size(), 0);

    $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
    $finish;
  end

endmodule
